// File: rtl/fetch_stage.sv
// Dual-issue fetch stage: issues paired imem requests, queues returned pairs
// show-ahead with BHT predict bits, and honours stall, flush and redirect.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned QDEPTH   = 4,
   parameter int unsigned MAX_OUT  = 2,
   parameter int unsigned BHT_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [15:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        bp_update_valid,
   input  logic [15:0] bp_update_pc,
   input  logic        bp_update_taken,
   output logic [15:0] I1,
   output logic [15:0] I2,
   output logic        I1V,
   output logic        I2V,
   output logic        I1P,
   output logic        I2P,
   output logic [15:0] I1PC,
   output logic [15:0] I2PC
);

   localparam int unsigned QW   = $clog2(QDEPTH);
   localparam int unsigned CW   = $clog2(QDEPTH + 1);
   localparam int unsigned AW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned NBHT = 1 << BHT_BITS;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
   localparam logic [CW-1:0] OMAX  = CW'(MAX_OUT);
   localparam logic [AW-1:0] ALAST = AW'(MAX_OUT - 1);

   typedef struct packed {
      logic [15:0] i1;
      logic [15:0] i2;
      logic [15:0] pc1;
      logic        p1;
      logic        p2;
   } entry_t;

   entry_t        qmem_q [QDEPTH];
   logic [15:0]   afifo_q [MAX_OUT];
   logic [1:0]    bht_q [NBHT];
   logic [QW-1:0] qhead_q, qhead_d, qtail_q, qtail_d;
   logic [CW-1:0] qcount_q, qcount_d, out_q, out_d, drop_q, drop_d;
   logic [AW-1:0] awr_q, awr_d, ard_q, ard_d;
   logic [15:0]   fetch_pc_q, fetch_pc_d;

   logic          req_fire, rsp_acc, push, pop;
   logic [CW:0]   credits;
   logic [15:0]   rsp_pc1, rsp_pc2;
   entry_t        push_entry, head;
   logic          unused_bp_bits;

   assign unused_bp_bits = ^{bp_update_pc[15:BHT_BITS+1], bp_update_pc[0]};

   function automatic logic [AW-1:0] aw_next(input logic [AW-1:0] p);
      return (p == ALAST) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      credits        = {1'b0, qcount_q} + {1'b0, out_q};
      imem_req_valid = !flush && !reset && (out_q < OMAX) && (credits < {1'b0, QFULL});
      imem_addr      = reset ? '0 : fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      // Responses with nothing outstanding (stale after reset) are ignored.
      rsp_acc        = imem_rsp_valid && (out_q != '0);
      pop            = (qcount_q != '0) && !stall && !flush;
      push           = rsp_acc && (drop_q == '0) && !flush && ((qcount_q != QFULL) || pop);

      rsp_pc1    = afifo_q[ard_q];
      rsp_pc2    = rsp_pc1 + 16'd2;
      push_entry = '{i1:  imem_rsp_data[15:0],
                     i2:  imem_rsp_data[31:16],
                     pc1: rsp_pc1,
                     p1:  bht_q[rsp_pc1[BHT_BITS:1]][1],
                     p2:  bht_q[rsp_pc2[BHT_BITS:1]][1]};

      out_d = out_q;
      if (req_fire && !rsp_acc)      out_d = out_q + CW'(1);
      else if (!req_fire && rsp_acc) out_d = out_q - CW'(1);

      drop_d = drop_q;
      if (flush)                          drop_d = out_d;
      else if (rsp_acc && drop_q != '0)   drop_d = drop_q - CW'(1);

      fetch_pc_d = fetch_pc_q;
      if (flush)         fetch_pc_d = redirect_pc;
      else if (req_fire) fetch_pc_d = fetch_pc_q + 16'd4;

      awr_d = req_fire ? aw_next(awr_q) : awr_q;
      ard_d = rsp_acc  ? aw_next(ard_q) : ard_q;

      qhead_d  = pop  ? qhead_q + QW'(1) : qhead_q;
      qtail_d  = push ? qtail_q + QW'(1) : qtail_q;
      qcount_d = qcount_q;
      if (push && !pop)      qcount_d = qcount_q + CW'(1);
      else if (!push && pop) qcount_d = qcount_q - CW'(1);
      if (flush) begin
         qhead_d  = '0;
         qtail_d  = '0;
         qcount_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         qhead_q    <= '0;
         qtail_q    <= '0;
         qcount_q   <= '0;
         out_q      <= '0;
         drop_q     <= '0;
         awr_q      <= '0;
         ard_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         qhead_q    <= qhead_d;
         qtail_q    <= qtail_d;
         qcount_q   <= qcount_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         awr_q      <= awr_d;
         ard_q      <= ard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NBHT; i++) bht_q[i] <= 2'b01;
      end else if (bp_update_valid) begin
         if (bp_update_taken && bht_q[bp_update_pc[BHT_BITS:1]] != 2'b11)
            bht_q[bp_update_pc[BHT_BITS:1]] <= bht_q[bp_update_pc[BHT_BITS:1]] + 2'b01;
         else if (!bp_update_taken && bht_q[bp_update_pc[BHT_BITS:1]] != 2'b00)
            bht_q[bp_update_pc[BHT_BITS:1]] <= bht_q[bp_update_pc[BHT_BITS:1]] - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push)     qmem_q[qtail_q] <= push_entry;
      if (!reset && req_fire) afifo_q[awr_q]  <= fetch_pc_q;
   end

   always_comb begin
      head = qmem_q[qhead_q];
      I1   = '0;
      I2   = '0;
      I1V  = 1'b0;
      I2V  = 1'b0;
      I1P  = 1'b0;
      I2P  = 1'b0;
      I1PC = '0;
      I2PC = '0;
      if (qcount_q != '0) begin
         I1   = head.i1;
         I2   = head.i2;
         I1V  = 1'b1;
         I2V  = 1'b1;
         I1P  = head.p1;
         I2P  = head.p2;
         I1PC = head.pc1;
         I2PC = head.pc1 + 16'd2;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order latency memory, queue-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_stage;

   localparam logic [15:0] RST = 16'h0010;
   localparam int QD = 4;
   localparam int MO = 2;

   logic        clk, reset, stall, flush;
   logic [15:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        bp_update_valid, bp_update_taken;
   logic [15:0] bp_update_pc;
   logic [15:0] I1, I2, I1PC, I2PC;
   logic        I1V, I2V, I1P, I2P;

   fetch_stage #(.RESET_PC(RST), .QDEPTH(QD), .MAX_OUT(MO), .BHT_BITS(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc), .bp_update_taken(bp_update_taken),
      .I1(I1), .I2(I2), .I1V(I1V), .I2V(I2V), .I1P(I1P), .I2P(I2P), .I1PC(I1PC), .I2PC(I2PC));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input bit ok, input string name, input logic [67:0] got, input logic [67:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] fmem(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // ---------------- memory: in-order, latency lat cycles ----------------
   typedef struct { logic [15:0] a; int due; } mreq_t;
   mreq_t       memq[$];
   mreq_t       mr;
   logic [15:0] acc_addr[$];
   logic [15:0] a2;
   int          lat = 1;

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (reset) memq.delete();
         else if (imem_req_valid && imem_req_ready) begin
            memq.push_back('{imem_addr, cyc + lat});
            acc_addr.push_back(imem_addr);
         end
         @(posedge clk);
         #1;
         if (memq.size() > 0 && memq[0].due <= cyc) begin
            mr = memq.pop_front();
            a2 = mr.a + 16'd2;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {fmem(a2), fmem(mr.a)};
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   typedef struct { logic [15:0] pc, i1, i2; logic p1, p2; } pair_t;
   pair_t       pm[$];
   pair_t       ne;
   logic [15:0] m_af[$];
   logic [15:0] m_pc = '0;
   logic [15:0] ra;
   int          m_out = 0, m_drop = 0;
   int          m_bht[16];
   bit          exp_req, fire, do_pop;
   logic [67:0] got_v, exp_v;

   always @(negedge clk) begin
      got_v = {I1V, I2V, I1P, I2P, I1, I2, I1PC, I2PC};
      if (pm.size() > 0) exp_v = {2'b11, pm[0].p1, pm[0].p2, pm[0].i1, pm[0].i2, pm[0].pc, pm[0].pc + 16'd2};
      else               exp_v = '0;
      chk(got_v === exp_v, "head", got_v, exp_v);
      exp_req = !reset && !flush && m_out < MO && (pm.size() + m_out) < QD;
      chk(imem_req_valid === exp_req, "req_valid", imem_req_valid, exp_req);
      if (exp_req) chk(imem_addr === m_pc, "imem_addr", imem_addr, m_pc);

      if (reset) begin
         pm.delete(); m_af.delete();
         m_out = 0; m_drop = 0; m_pc = RST;
         foreach (m_bht[i]) m_bht[i] = 1;
      end else begin
         fire   = exp_req && imem_req_ready;
         do_pop = pm.size() > 0 && !stall && !flush;
         if (fire) begin
            m_af.push_back(m_pc);
            m_pc += 16'd4;
            m_out++;
         end
         if (imem_rsp_valid && m_out > 0) begin
            ra = m_af.pop_front();
            m_out--;
            if (m_drop > 0) m_drop--;
            else if (!flush) begin
               ne.pc = ra;
               ne.i1 = imem_rsp_data[15:0];
               ne.i2 = imem_rsp_data[31:16];
               ne.p1 = m_bht[ra[4:1]] >= 2;
               a2    = ra + 16'd2;
               ne.p2 = m_bht[a2[4:1]] >= 2;
               chk((pm.size() - (do_pop ? 1 : 0)) < QD, "q_overflow", pm.size(), QD);
               pm.push_back(ne);
            end
         end
         if (do_pop) void'(pm.pop_front());
         if (bp_update_valid) begin
            if (bp_update_taken && m_bht[bp_update_pc[4:1]] < 3) m_bht[bp_update_pc[4:1]]++;
            else if (!bp_update_taken && m_bht[bp_update_pc[4:1]] > 0) m_bht[bp_update_pc[4:1]]--;
         end
         if (flush) begin
            pm.delete();
            m_pc   = redirect_pc;
            m_drop = m_out;
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic wait_valid(input int max, input string name);
      bit got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         @(negedge clk);
         got = I1V;
      end
      if (!got) chk(1'b0, name, 0, 1);
   endtask

   logic [15:0] seen[$];
   logic [15:0] prev;
   int nv, ns;

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; bp_update_valid = 1'b0; bp_update_pc = '0; bp_update_taken = 1'b0;
      @(negedge clk);
      chk(I1V === 1'b0 && imem_req_valid === 1'b0 && I1PC === 16'h0, "reset_outputs", {I1V, imem_req_valid, I1PC}, 0);
      tick(); tick();

      // first pairs after reset, 1-cycle memory
      reset = 1'b0;
      acc_addr.delete();
      wait_valid(20, "t1_timeout");
      chk(I1PC === 16'h0010 && I2PC === 16'h0012, "t1_pcs", {I1PC, I2PC}, {16'h0010, 16'h0012});
      chk(I1P === 1'b0 && I2P === 1'b0 && I2V === 1'b1, "t1_pred", {I1P, I2P, I2V}, 3'b001);
      repeat (3) tick();
      chk(acc_addr.size() >= 3, "t1_nacc", acc_addr.size(), 3);
      if (acc_addr.size() >= 3)
         chk(acc_addr[0] === 16'h0010 && acc_addr[1] === 16'h0014 && acc_addr[2] === 16'h0018,
             "t1_addr_seq", {acc_addr[0], acc_addr[1], acc_addr[2]}, {16'h0010, 16'h0014, 16'h0018});

      // sustained one pair per cycle
      nv = 0; ns = 0; prev = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (I1V) nv++;
         if (i > 0 && I1PC === prev + 16'd4) ns++;
         prev = I1PC;
      end
      chk(nv == 12, "t6_valid_run", nv, 12);
      chk(ns == 11, "t6_pc_step", ns, 11);

      // stall held from reset: credits cap accepted requests at QDEPTH
      tick();
      reset = 1'b1; stall = 1'b1;
      tick(); tick();
      reset = 1'b0;
      acc_addr.delete();
      repeat (10) tick();
      @(negedge clk);
      chk(acc_addr.size() == 4, "t2_nacc", acc_addr.size(), 4);
      chk(imem_req_valid === 1'b0, "t2_req_off", imem_req_valid, 0);
      chk(I1V === 1'b1 && I1PC === 16'h0010, "t2_frozen", {I1V, I1PC}, {1'b1, 16'h0010});
      tick();
      stall = 1'b0;
      seen.delete();
      for (int i = 0; i < 12 && seen.size() < 6; i++) begin
         @(negedge clk);
         if (I1V) seen.push_back(I1PC);
      end
      chk(seen.size() == 6, "t2_nseen", seen.size(), 6);
      for (int i = 0; i < 6 && i < seen.size(); i++)
         chk(seen[i] === 16'h0010 + 16'(4 * i), "t2_order", seen[i], 16'h0010 + 16'(4 * i));

      // flush with two requests in flight, latency 3
      tick();
      reset = 1'b1;
      tick(); tick();
      lat = 3;
      reset = 1'b0;
      acc_addr.delete();
      tick(); tick();
      flush = 1'b1; redirect_pc = 16'h0100;
      @(negedge clk);
      chk(acc_addr.size() == 2, "t3_inflight", acc_addr.size(), 2);
      tick();
      flush = 1'b0;
      wait_valid(30, "t3_timeout");
      chk(I1PC === 16'h0100 && I2PC === 16'h0102, "t3_redirect", {I1PC, I2PC}, {16'h0100, 16'h0102});

      // BHT training at 0104
      tick();
      bp_update_valid = 1'b1; bp_update_pc = 16'h0104; bp_update_taken = 1'b1;
      tick(); tick(); tick();
      bp_update_valid = 1'b0;
      flush = 1'b1; redirect_pc = 16'h0104;
      tick();
      flush = 1'b0;
      wait_valid(30, "t4_timeout");
      chk(I1PC === 16'h0104 && I1P === 1'b1 && I2P === 1'b0, "t4_predict", {I1PC, I1P, I2P}, {16'h0104, 2'b10});

      // PC wrap at the top of the address space
      tick();
      lat = 1;
      flush = 1'b1; redirect_pc = 16'hFFFC;
      acc_addr.delete();
      tick();
      flush = 1'b0;
      wait_valid(30, "t5_timeout");
      chk(I1PC === 16'hFFFC && I2PC === 16'hFFFE, "t5_pcs", {I1PC, I2PC}, {16'hFFFC, 16'hFFFE});
      repeat (3) tick();
      chk(acc_addr.size() >= 2, "t5_nacc", acc_addr.size(), 2);
      if (acc_addr.size() >= 2)
         chk(acc_addr[0] === 16'hFFFC && acc_addr[1] === 16'h0000, "t5_wrap_addr",
             {acc_addr[0], acc_addr[1]}, {16'hFFFC, 16'h0000});
      flush = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      flush = 1'b0;
      wait_valid(30, "t5b_timeout");
      chk(I1PC === 16'hFFFE && I2PC === 16'h0000, "t5_wrap_pc2", {I1PC, I2PC}, {16'hFFFE, 16'h0000});

      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Dual-issue instruction fetch stage; the producer side of the IF/ID pipeline register.
- Generates PCs and issues requests to instruction memory.
- Buffers returned instruction pairs in a small show-ahead queue.
- Presents one pair per cycle as I1/I2 with valid, PC and predict bits.
- Honours IF/ID stall and pipeline flush/redirect. Holds a 2-bit-counter branch history table (BHT) that supplies the predict bits.

Parameters:
RESET_PC, 16'h0000, PC fetched first after reset
QDEPTH, 4, fetch queue entries (pairs); power of two, >=2
MAX_OUT, 2, max outstanding imem requests; MAX_OUT <= QDEPTH
BHT_BITS, 4, log2 of BHT entries

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
stall  in  1  IF/ID stall; head pair is not consumed
flush  in  1  discard queue and in-flight fetches; restart at redirect_pc
redirect_pc  in  16  new fetch PC, sampled when flush=1
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  16  byte address of first instruction of pair
imem_rsp_valid  in  1  response valid; responses return in order, latency >=1
imem_rsp_data  in  32  [15:0] instr at addr, [31:16] instr at addr+2
bp_update_valid  in  1  resolved-branch BHT update
bp_update_pc  in  16  PC of resolved branch
bp_update_taken  in  1  actual outcome
I1, I2  out  16 each  head-pair instructions
I1V, I2V  out  1 each  head-pair valid
I1P, I2P  out  1 each  predicted-taken bits
I1PC, I2PC  out  16 each  PCs of I1/I2

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0.
  - Every BHT counter = 2'b01 (weakly not taken).
  - All outputs 0, including imem_req_valid.
- Issue:
  - imem_req_valid=1 when !flush && !reset && outstanding<MAX_OUT && (queue_count+outstanding)<QDEPTH.
  - imem_addr=fetch_pc.
  - On a req handshake, fetch_pc += 4 (16-bit wrap) and outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise push an entry {I1=data[15:0], I2=data[31:16], PC1=req addr, PC2=PC1+2 mod 2^16, P1, P2}. Request addresses are held in a MAX_OUT-deep address FIFO.
  - The credit rule guarantees a push never finds the queue full. A push into a full queue is a design error; it must not corrupt state, and the bench asserts it never occurs.
- Prediction:
  - At push, P1=BHT[PC1[BHT_BITS:1]][1] and P2=BHT[PC2[BHT_BITS:1]][1].
  - An update in the same cycle does not affect that read; the old value is used.
- BHT update:
  - On bp_update_valid, BHT[bp_update_pc[BHT_BITS:1]] saturating increments if taken, decrements if not.
  - Limits are 00 and 11.
- Outputs (combinational from queue head, show-ahead):
  - Queue non-empty: I1V=I2V=1 and the fields come from the head entry.
  - Queue empty: all outputs 0.
- Pop: head is removed when queue non-empty && !stall && !flush. Push and pop may occur in the same cycle; count is unchanged.
- Flush (priority over stall, pop and push):
  - Queue cleared; fetch_pc=redirect_pc.
  - drop = outstanding_next, i.e. outstanding after this cycle's handshakes, including a response arriving this cycle.
  - imem_req_valid=0 in the flush cycle; issue resumes the next cycle at redirect_pc.
- Stall with empty queue has no effect. Stall holds the head and outputs stable; fetch continues until credits run out.
- Simultaneous req handshake and response in one cycle: outstanding unchanged.
- Reset takes priority over flush. Reset mid-transfer discards all state; a late response after reset is counted against outstanding=0 and must be dropped. Drop is forced to MAX_OUT for MAX_OUT cycles after reset only if memory can deliver late responses. The top level guarantees memory is also reset, so no late response occurs.

Test Plan:
- Reset with RESET_PC=16'h0010, ready=1, 1-cycle memory → imem_addr sequence 0010,0014,0018; first outputs I1PC=0010, I2PC=0012, I1V=I2V=1, I1P=I2P=0.
- stall=1 held 10 cycles → outputs frozen at the same head, exactly QDEPTH=4 requests total accepted, then imem_req_valid=0; release → pairs appear in order with no loss or duplication.
- Two requests outstanding (latency 3), flush with redirect_pc=16'h0100 → both stale responses dropped; next I1PC=0100, I2PC=0102.
- Three bp_update taken at PC 16'h0104 → counter 01→10→11→11; later fetch of pair at 0104 gives I1P=1, while PC 0106 gives I2P=0.
- fetch_pc=16'hFFFC → next imem_addr 0000; pair at FFFE gives I2PC=0000.
- Push and pop in same cycle with full-rate memory, stall=0 → one pair per cycle sustained, queue count constant, no bubbles after the first.
